// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca -- multicycle fetch/sequencer feeding the instruction decoder.
//
// Holds the PC and fetches one 32-bit word per instruction over a req/ack
// handshake. The word is latched on `instrucao`, and the 4-bit `estado` bus
// steps the downstream stages. The execute stage returns the branch outcome
// on desvio/alvo, which is sampled only while estado == EXECUTA.
//
// Parameters:
//   PC_INICIAL  PC value loaded at reset
//   TIMEOUT     number of unacknowledged request cycles before ERRO (2..255)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous reset, active low
//   mem_req       out  instruction-memory read request
//   mem_endereco  out  read address (== pc while mem_req = 1)
//   mem_ack       in   mem_dado is valid this cycle
//   mem_dado      in   instruction word from memory
//   desvio        in   branch/jump taken (sampled in EXECUTA)
//   alvo          in   branch target (sampled with desvio)
//   instrucao     out  latched instruction word
//   pc            out  address of the instruction held in `instrucao`
//   estado        out  current stage code
//   erro          out  sticky fault flag (cleared only by rst_n)
//
// Build option:
//   MISALIGN_TRAP_EN  If defined, a taken branch to a target that is not
//                     word-aligned faults into ERRO. If undefined, the low two
//                     bits of the target are cleared and no fault is raised.
// -----------------------------------------------------------------------------
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_ack,
  input  logic [31:0] mem_dado,
  input  logic        desvio,
  input  logic [31:0] alvo,
  output logic [31:0] instrucao,
  output logic [31:0] pc,
  output logic [3:0]  estado,
  output logic        erro
);

  localparam logic [3:0] BUSCA      = 4'b0000;
  localparam logic [3:0] DECODIFICA = 4'b0001;
  localparam logic [3:0] EXECUTA    = 4'b0010;
  localparam logic [3:0] MEMORIA    = 4'b0011;
  localparam logic [3:0] ESCRITA    = 4'b0100;
  localparam logic [3:0] ERRO       = 4'b1111;

  // Last count value before the request is declared lost.
  localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

  logic [7:0]  contador;
  logic [31:0] pc_prox_reg;

  logic [2:0]  classe;
  logic        desvio_valido;
  logic        armadilha;
  logic [31:0] pc_mais4;
  logic [31:0] pc_calc;
  logic [3:0]  exec_prox;

  // Instruction class in bits [6:4]. Unknown classes are no-ops, so the
  // branch outcome is not applied to them.
  always_comb begin
    classe        = instrucao[6:4];
    desvio_valido = 1'b0;
    exec_prox     = BUSCA;
    case (classe)
      3'b000, 3'b010: begin desvio_valido = 1'b1; exec_prox = MEMORIA; end
      3'b001, 3'b011: begin desvio_valido = 1'b1; exec_prox = ESCRITA; end
      3'b110:         begin desvio_valido = 1'b1; exec_prox = BUSCA;   end
      default:        begin desvio_valido = 1'b0; exec_prox = BUSCA;   end
    endcase

    pc_mais4 = pc + 32'd4;  // modulo 2^32 wrap, no flag
    pc_calc  = (desvio_valido && desvio) ? (alvo & ~32'h3) : pc_mais4;

`ifdef MISALIGN_TRAP_EN
    armadilha = desvio_valido && desvio && (alvo[1:0] != 2'b00);
`else
    armadilha = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= BUSCA;
      pc           <= PC_INICIAL;
      instrucao    <= 32'h0;
      mem_req      <= 1'b0;
      mem_endereco <= 32'h0;
      erro         <= 1'b0;
      contador     <= 8'h0;
      pc_prox_reg  <= 32'h0;
    end else begin
      case (estado)
        BUSCA: begin
          if (!mem_req) begin
            // First cycle after reset: raise the request. An ack here
            // has no outstanding request behind it and is dropped.
            mem_req      <= 1'b1;
            mem_endereco <= pc;
          end else if (mem_ack) begin
            // Ack beats the timeout even on the last allowed cycle.
            instrucao <= mem_dado;
            mem_req   <= 1'b0;
            contador  <= 8'h0;
            estado    <= DECODIFICA;
          end else if (contador == LIMITE) begin
            erro     <= 1'b1;
            mem_req  <= 1'b0;
            contador <= 8'h0;
            estado   <= ERRO;
          end else begin
            contador <= contador + 8'd1;
          end
        end

        DECODIFICA: estado <= EXECUTA;

        EXECUTA: begin
          if (armadilha) begin
            erro   <= 1'b1;
            estado <= ERRO;
          end else begin
            pc_prox_reg <= pc_calc;
            if (exec_prox == BUSCA) begin
              // Request is raised together with the PC update so
              // the new fetch starts on the first BUSCA cycle.
              pc           <= pc_calc;
              mem_req      <= 1'b1;
              mem_endereco <= pc_calc;
            end
            estado <= exec_prox;
          end
        end

        MEMORIA: begin
          if (classe == 3'b000) begin
            estado <= ESCRITA;
          end else begin
            pc           <= pc_prox_reg;
            mem_req      <= 1'b1;
            mem_endereco <= pc_prox_reg;
            estado       <= BUSCA;
          end
        end

        ESCRITA: begin
          pc           <= pc_prox_reg;
          mem_req      <= 1'b1;
          mem_endereco <= pc_prox_reg;
          estado       <= BUSCA;
        end

        ERRO: begin
          // Absorbing: everything frozen until rst_n.
          mem_req <= 1'b0;
          erro    <= 1'b1;
        end

        default: begin
          // Unreachable codes are treated as a fault.
          mem_req <= 1'b0;
          erro    <= 1'b1;
          estado  <= ERRO;
        end
      endcase
    end
  end

endmodule
